key_pad_emulator: RTL
=====================

KEY_PAD_EMULATOR -- requirements
Module: key_pad_emulator

Interface
REQ-001 The block SHALL have parameter BOUNCE_CYCLES, default 3: contact-chatter cycles at press and at release (0 = clean edges).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: guaranteed open cycles after release, before completion.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port kp_row, input, 4: row drive from the keypad scanner, one bit low = row selected.
REQ-006 The block SHALL have port kp_col, output, 4: column return to the scanner, active-low, 4'b1111 = no contact.
REQ-007 The block SHALL have port cmd_valid, input, 1: press command offered.
REQ-008 The block SHALL have port cmd_ready, output, 1: block can accept a command.
REQ-009 The block SHALL have port cmd_key, input, 4: key code to press (0-F).
REQ-010 The block SHALL have port cmd_hold, input, 8: number of stable-closed cycles.
REQ-011 The block SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-012 The block SHALL have port done, output, 1: one-cycle pulse when a press sequence completes.

Function
REQ-013 Key map (row pattern / column pattern) SHALL be exactly:
- row 1110, cols 1110/1101/1011/0111 = 7/4/1/0
- row 1101 = 8/5/2/A
- row 1011 = 9/6/3/B
- row 0111 = C/D/E/F
REQ-014 kp_col SHALL be combinational from kp_row and a registered contact bit: the key's column pattern when contact=1 and kp_row equals the key's row pattern; otherwise 4'b1111.
REQ-015 A kp_row value with other than exactly one zero bit SHALL yield kp_col=4'b1111.
REQ-016 The FSM states SHALL be IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
- A command is accepted on the edge where cmd_valid&&cmd_ready.
- On acceptance, cmd_key and cmd_hold are latched; later input changes are ignored.
REQ-018 On acceptance the FSM SHALL enter BOUNCE_IN, or HOLD if BOUNCE_CYCLES=0.
REQ-019 BOUNCE_IN SHALL last BOUNCE_CYCLES cycles, with contact toggling every cycle starting closed (1,0,1,...).
REQ-020 HOLD SHALL keep contact=1 for cmd_hold cycles; cmd_hold=0 SHALL be treated as 1.
REQ-021 BOUNCE_OUT SHALL last BOUNCE_CYCLES cycles, toggling starting open (0,1,0,...); it is skipped if BOUNCE_CYCLES=0.
REQ-022 GAP SHALL hold contact=0 for GAP_CYCLES cycles (minimum 1 even if parameter is 0), then return to IDLE.
REQ-023 done SHALL be 1 for exactly the first IDLE cycle after GAP.
- It coincides with cmd_ready=1.
- A command accepted in that cycle is legal and starts the next sequence with no extra gap.
REQ-024 The first closed cycle SHALL be the cycle immediately after the acceptance edge; no other latency is permitted.
REQ-025 Total busy duration SHALL be 2*BOUNCE_CYCLES + max(cmd_hold,1) + max(GAP_CYCLES,1) cycles.
REQ-026 Duration counters SHALL be 8 bits, count down, with no wrap-around: the state exits on count==1.
REQ-027 cmd_valid while busy SHALL be ignored with no queuing.

Reset
REQ-028 While rst=0 the block SHALL hold: state IDLE, contact=0, kp_col=4'b1111, busy=0, done=0, counters=0, latched key=0, hold=0.
REQ-029 While rst=0, cmd_ready SHALL be 0; it SHALL be 1 from the first clock edge after rst rises.
REQ-030 Assertion of rst mid-sequence SHALL release the key immediately (asynchronously) and SHALL NOT produce done.

Verification
REQ-031 Scan key 8, BOUNCE=0, GAP=4, hold=8:
- Stimulus: bench cycles kp_row 1110->1101->1011->0111.
- Response: kp_col=1110 only in cycles where kp_row=1101, for 8 cycles; busy for 12 cycles; single done pulse.
REQ-032 Bounce on key A, BOUNCE=3, hold=2, kp_row fixed 1101:
- kp_col sequence SHALL be 0111,1111,0111, 0111,0111, 1111,0111,1111, then 1111 for 4 cycles.
- done SHALL be high in cycle 13.
REQ-033 Busy rejection: key 0 accepted, then cmd_valid held with key 7:
- cmd_ready=0 throughout.
- Key 7 is accepted in the done cycle.
- Row 1110 then shows 0111 for the first press and 1110 for the second.
REQ-034 hold=0 on key F, BOUNCE=0, GAP=4: exactly one closed cycle (kp_col=0111 when kp_row=0111); busy 5 cycles.
REQ-035 Reset mid-HOLD of key 5, kp_row=1110: kp_col=1111 during the rst-low window (no clock needed); no done; cmd_ready=1 one edge after release.
REQ-036 Illegal rows: kp_row 1100, 1111, 0000 during HOLD SHALL each give kp_col=1111.

Source files
------------

// File: rtl/key_pad_emulator.sv
// Matrix-keypad key-press emulator: answers a row scanner with the column
// pattern of a commanded key, including contact bounce, hold and release gap.
module key_pad_emulator #(
  parameter int BOUNCE_CYCLES = 3,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  localparam logic [7:0] BNC  = 8'(BOUNCE_CYCLES);
  localparam logic [7:0] GAPN =
    (GAP_CYCLES == 0) ? 8'd1 : 8'(GAP_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       contact_q, contact_d;
  logic [3:0] key_q, key_d;
  logic [7:0] hold_q, hold_d;
  logic       done_q, done_d;
  logic       ready_q;

  logic [7:0] hold_src;
  logic [7:0] hold_len;
  logic [3:0] row_pat;
  logic [3:0] col_pat;

  // With no bounce the hold count is loaded straight from the command.
  assign hold_src  = (state_q == IDLE) ? cmd_hold : hold_q;
  assign hold_len  = (hold_src == 8'd0) ? 8'd1 : hold_src;

  assign cmd_ready = ready_q && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    row_pat = 4'b1111;
    col_pat = 4'b1111;
    unique case (key_q)
      4'h0: {row_pat, col_pat} = 8'b1110_0111;
      4'h1: {row_pat, col_pat} = 8'b1110_1011;
      4'h2: {row_pat, col_pat} = 8'b1101_1011;
      4'h3: {row_pat, col_pat} = 8'b1011_1011;
      4'h4: {row_pat, col_pat} = 8'b1110_1101;
      4'h5: {row_pat, col_pat} = 8'b1101_1101;
      4'h6: {row_pat, col_pat} = 8'b1011_1101;
      4'h7: {row_pat, col_pat} = 8'b1110_1110;
      4'h8: {row_pat, col_pat} = 8'b1101_1110;
      4'h9: {row_pat, col_pat} = 8'b1011_1110;
      4'hA: {row_pat, col_pat} = 8'b1101_0111;
      4'hB: {row_pat, col_pat} = 8'b1011_0111;
      4'hC: {row_pat, col_pat} = 8'b0111_1110;
      4'hD: {row_pat, col_pat} = 8'b0111_1101;
      4'hE: {row_pat, col_pat} = 8'b0111_1011;
      4'hF: {row_pat, col_pat} = 8'b0111_0111;
    endcase
  end

  // row_pat always has one zero, so illegal row drives never match.
  assign kp_col = (contact_q && (kp_row == row_pat)) ? col_pat : 4'b1111;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    contact_d = contact_q;
    key_d     = key_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          key_d     = cmd_key;
          hold_d    = cmd_hold;
          contact_d = 1'b1;
          if (BNC != 8'd0) begin
            state_d = BOUNCE_IN;
            cnt_d   = BNC;
          end else begin
            state_d = HOLD;
            cnt_d   = hold_len;
          end
        end
      end
      BOUNCE_IN: begin
        if (cnt_q == 8'd1) begin
          state_d   = HOLD;
          cnt_d     = hold_len;
          contact_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - 8'd1;
          contact_d = ~contact_q;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd1) begin
          contact_d = 1'b0;
          if (BNC != 8'd0) begin
            state_d = BOUNCE_OUT;
            cnt_d   = BNC;
          end else begin
            state_d = GAP;
            cnt_d   = GAPN;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BOUNCE_OUT: begin
        if (cnt_q == 8'd1) begin
          state_d   = GAP;
          cnt_d     = GAPN;
          contact_d = 1'b0;
        end else begin
          cnt_d     = cnt_q - 8'd1;
          contact_d = ~contact_q;
        end
      end
      GAP: begin
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        contact_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      contact_q <= 1'b0;
      key_q     <= 4'd0;
      hold_q    <= 8'd0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      ready_q   <= 1'b1;
    end
  end

endmodule
